// File: rtl/xilinx_sp_bram_array.sv
// Depth-tiled single-port BRAM array with a latency-aligned read return path.
// Define XILINX_SP_BRAM_ARRAY_CLEAR_EN to zero-fill every tile after reset.
module xilinx_sp_bram_array #(
  parameter BRAM_SIZE = "18Kb",
  parameter DEVICE = "7SERIES",
  parameter int DO_REG = 0,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  parameter int TILE_DEPTH = 512,
  parameter WRITE_MODE = "WRITE_FIRST",
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int WE_WIDTH = (WIDTH + 7) / 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ,
  output logic                READY,
  input  logic [WE_WIDTH-1:0] WE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [WIDTH-1:0]    DI,
  output logic [WIDTH-1:0]    DO,
  output logic                DO_VALID,
  output logic                ERR
);

  localparam int TA_W = $clog2(TILE_DEPTH);
  localparam int NUM_TILES = (DEPTH + TILE_DEPTH - 1) / TILE_DEPTH;
  localparam int LAT = 1 + DO_REG;
  localparam int TI_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int MODE = (WRITE_MODE == "READ_FIRST") ? 1 :
                        (WRITE_MODE == "NO_CHANGE") ? 2 : 0;

  if (BRAM_SIZE != "18Kb" && BRAM_SIZE != "36Kb") begin : g_bad_size
    $error("BRAM_SIZE must be 18Kb or 36Kb");
  end
  if (DEVICE == "") begin : g_bad_dev
    $error("DEVICE must be set");
  end
  if ((1 << TA_W) != TILE_DEPTH) begin : g_bad_td
    $error("TILE_DEPTH must be a power of two");
  end

  logic                ready_q;
  logic                clr;
  logic [TA_W-1:0]     clr_addr;
  logic                acc;
  logic                in_rng;
  logic                is_rd;
  logic [TI_W-1:0]     tsel;
  logic [TA_W-1:0]     t_addr;
  logic [WE_WIDTH-1:0] t_we;
  logic [WIDTH-1:0]    t_di;
  logic [WIDTH-1:0]    t_mask;
  logic                t_wr;
  logic [WIDTH-1:0]    t_do [NUM_TILES];

  assign READY = ready_q;
  assign acc = REQ & ready_q;
  assign in_rng = 32'(ADDR) < DEPTH;
  assign is_rd = (WE == '0);
  assign tsel = TI_W'(ADDR >> TA_W);

  assign t_addr = clr ? clr_addr : TA_W'(ADDR);
  assign t_we = clr ? '1 : WE;
  assign t_di = clr ? '0 : DI;
  assign t_wr = |t_we;

  always_comb begin
    t_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_mask[i] = t_we[i / 8];
    end
  end

`ifdef XILINX_SP_BRAM_ARRAY_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [TA_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEAR;
      cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == TA_W'(TILE_DEPTH - 1)) begin
            state <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ready_q <= 1'b1;
      endcase
    end
  end

  assign clr = (state == CLEAR);
  assign clr_addr = cnt;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ready_q <= 1'b1;
    else     ready_q <= 1'b1;
  end

  assign clr = 1'b0;
  assign clr_addr = '0;
`endif

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    logic             en;
    logic [WIDTH-1:0] mem [TILE_DEPTH];
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] wr;
    logic [WIDTH-1:0] lat;
    logic [WIDTH-1:0] q;

    assign en = clr | (acc & in_rng & (tsel == TI_W'(t)));
    assign rd = mem[t_addr];
    assign wr = (rd & ~t_mask) | (t_di & t_mask);

    always_ff @(posedge CLK) begin
      if (en && t_wr) mem[t_addr] <= wr;
    end

    // Array latch models the primitive's read port per write mode.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        lat <= '0;
      end else if (en) begin
        if (!t_wr)          lat <= rd;
        else if (MODE == 0) lat <= wr;
        else if (MODE == 1) lat <= rd;
      end
    end

    if (DO_REG != 0) begin : g_reg
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) q <= '0;
        else     q <= lat;
      end
    end else begin : g_nreg
      assign q = lat;
    end

    assign t_do[t] = q;
  end

  logic [LAT-1:0]  pv;
  logic [LAT-1:0]  pe;
  logic [TI_W-1:0] ps [LAT];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LAT; i++) ps[i] <= '0;
    end else begin
      pv[0] <= acc & is_rd;
      pe[0] <= acc & ~in_rng;
      ps[0] <= tsel;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end

  // Each response picks its tile via its own delayed select.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DO_VALID <= 1'b0;
      ERR <= 1'b0;
      DO <= '0;
    end else begin
      DO_VALID <= pv[LAT-1];
      ERR <= pe[LAT-1];
      DO <= (pv[LAT-1] & ~pe[LAT-1]) ? t_do[ps[LAT-1]] : '0;
    end
  end

endmodule
